// File: rtl/vga_pkg.sv
// Shared types, default 640x480@60 Hz timing and counter width for the VGA raster controller.
package vga_pkg;

   localparam int unsigned ANCHO = 10;

   localparam int unsigned DEF_H_VISIBLE = 640;
   localparam int unsigned DEF_H_PF      = 16;
   localparam int unsigned DEF_H_SYNC    = 96;
   localparam int unsigned DEF_H_PT      = 48;
   localparam int unsigned DEF_V_VISIBLE = 480;
   localparam int unsigned DEF_V_PF      = 10;
   localparam int unsigned DEF_V_SYNC    = 2;
   localparam int unsigned DEF_V_PT      = 33;
   localparam int unsigned DEF_GUARDA    = 1;

   typedef enum logic [1:0] {
      VISIBLE,
      PORCHE_FRONTAL,
      SINCRONIA,
      PORCHE_TRASERO
   } fase_t;

endpackage

// File: rtl/controlador_vga_if.sv
// Pixel strobe, frame-buffer request/grant and registered raster outputs of the VGA controller.
interface controlador_vga_if;
   import vga_pkg::*;

   logic             pulso_pixel;
   logic             solicitud;
   logic [ANCHO-1:0] columna;
   logic [ANCHO-1:0] fila;
   logic             hsync_n;
   logic             vsync_n;
   logic             video_activo;
   logic             inicio_cuadro;
   logic             permiso;

   modport master (
      output pulso_pixel, solicitud,
      input  columna, fila, hsync_n, vsync_n, video_activo, inicio_cuadro, permiso
   );

   modport slave (
      input  pulso_pixel, solicitud,
      output columna, fila, hsync_n, vsync_n, video_activo, inicio_cuadro, permiso
   );

endinterface

// File: rtl/contador_fase.sv
// One raster axis: position counter plus VISIBLE/porch/sync phase FSM.
// Exposes next-state values so the parent can register decoded outputs on the same edge.
module contador_fase
   import vga_pkg::*;
#(
   parameter int unsigned VISIBLE_LEN = DEF_H_VISIBLE,
   parameter int unsigned PF_LEN      = DEF_H_PF,
   parameter int unsigned SYNC_LEN    = DEF_H_SYNC,
   parameter int unsigned PT_LEN      = DEF_H_PT
) (
   input  logic             reloj,
   input  logic             reset,
   input  logic             habilitar,
   output logic [ANCHO-1:0] cuenta_sig_c,
   output fase_t            fase_sig_c,
   output logic             envuelve_c
);

   localparam int unsigned TOTAL = VISIBLE_LEN + PF_LEN + SYNC_LEN + PT_LEN;

   localparam logic [ANCHO-1:0] ULTIMO   = ANCHO'(TOTAL - 1);
   localparam logic [ANCHO-1:0] INI_PF   = ANCHO'(VISIBLE_LEN);
   localparam logic [ANCHO-1:0] INI_SYNC = ANCHO'(VISIBLE_LEN + PF_LEN);
   localparam logic [ANCHO-1:0] INI_PT   = ANCHO'(VISIBLE_LEN + PF_LEN + SYNC_LEN);

   logic [ANCHO-1:0] cuenta;
   fase_t            fase;

   // Reset parks the axis on its last position so the first tick lands on 0.
   always_ff @(posedge reloj or posedge reset) begin
      if (reset) begin
         cuenta <= ULTIMO;
         fase   <= PORCHE_TRASERO;
      end else begin
         cuenta <= cuenta_sig_c;
         fase   <= fase_sig_c;
      end
   end

   always_comb begin
      cuenta_sig_c = cuenta;
      fase_sig_c   = fase;
      envuelve_c   = 1'b0;
      if (habilitar) begin
         if (cuenta == ULTIMO) begin
            cuenta_sig_c = '0;
            envuelve_c   = 1'b1;
         end else begin
            cuenta_sig_c = cuenta + ANCHO'(1);
         end
         // Phase changes on the tick that lands on the first position of the next segment.
         case (fase)
            VISIBLE:        if (cuenta_sig_c == INI_PF)   fase_sig_c = PORCHE_FRONTAL;
            PORCHE_FRONTAL: if (cuenta_sig_c == INI_SYNC) fase_sig_c = SINCRONIA;
            SINCRONIA:      if (cuenta_sig_c == INI_PT)   fase_sig_c = PORCHE_TRASERO;
            PORCHE_TRASERO: if (cuenta_sig_c == '0)       fase_sig_c = VISIBLE;
         endcase
      end
   end

endmodule

// File: rtl/controlador_vga.sv
// VGA raster sequencer: H/V counters, registered sync/video/frame-start decode and a
// frame-buffer write grant restricted to the vertical-blanking window.
module controlador_vga
   import vga_pkg::*;
#(
   parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
   parameter int unsigned H_PF      = DEF_H_PF,
   parameter int unsigned H_SYNC    = DEF_H_SYNC,
   parameter int unsigned H_PT      = DEF_H_PT,
   parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
   parameter int unsigned V_PF      = DEF_V_PF,
   parameter int unsigned V_SYNC    = DEF_V_SYNC,
   parameter int unsigned V_PT      = DEF_V_PT,
   parameter int unsigned GUARDA    = DEF_GUARDA
) (
   input  logic        reloj,
   input  logic        reset,
   controlador_vga_if.slave bus
);

   localparam int unsigned H_TOTAL = H_VISIBLE + H_PF + H_SYNC + H_PT;
   localparam int unsigned V_TOTAL = V_VISIBLE + V_PF + V_SYNC + V_PT;

   localparam logic [ANCHO-1:0] V_ABRE   = ANCHO'(V_VISIBLE);
   localparam logic [ANCHO-1:0] V_CIERRA = ANCHO'(V_TOTAL - GUARDA);

   logic [ANCHO-1:0] h_cuenta_sig_c;
   logic [ANCHO-1:0] v_cuenta_sig_c;
   fase_t            h_fase_sig_c;
   fase_t            v_fase_sig_c;
   logic             h_envuelve_c;
   logic             v_envuelve_c;
   logic             v_habilitar_c;
   logic             ventana_sig_c;

   contador_fase #(
      .VISIBLE_LEN (H_VISIBLE),
      .PF_LEN      (H_PF),
      .SYNC_LEN    (H_SYNC),
      .PT_LEN      (H_PT)
   ) u_horizontal (
      .reloj        (reloj),
      .reset        (reset),
      .habilitar    (bus.pulso_pixel),
      .cuenta_sig_c (h_cuenta_sig_c),
      .fase_sig_c   (h_fase_sig_c),
      .envuelve_c   (h_envuelve_c)
   );

   assign v_habilitar_c = h_envuelve_c & bus.pulso_pixel;

   contador_fase #(
      .VISIBLE_LEN (V_VISIBLE),
      .PF_LEN      (V_PF),
      .SYNC_LEN    (V_SYNC),
      .PT_LEN      (V_PT)
   ) u_vertical (
      .reloj        (reloj),
      .reset        (reset),
      .habilitar    (v_habilitar_c),
      .cuenta_sig_c (v_cuenta_sig_c),
      .fase_sig_c   (v_fase_sig_c),
      .envuelve_c   (v_envuelve_c)
   );

   // Blanking window in terms of the line being entered; the last GUARDA lines issue no grant.
   assign ventana_sig_c = (v_cuenta_sig_c >= V_ABRE) && (v_cuenta_sig_c < V_CIERRA);

   // Position mirrored here so the outputs and their decode move on the same edge.
   always_ff @(posedge reloj or posedge reset) begin
      if (reset) begin
         bus.columna       <= ANCHO'(H_TOTAL - 1);
         bus.fila          <= ANCHO'(V_TOTAL - 1);
         bus.hsync_n       <= 1'b1;
         bus.vsync_n       <= 1'b1;
         bus.video_activo  <= 1'b0;
         bus.inicio_cuadro <= 1'b0;
         bus.permiso       <= 1'b0;
      end else begin
         bus.columna       <= h_cuenta_sig_c;
         bus.fila          <= v_cuenta_sig_c;
         bus.hsync_n       <= (h_fase_sig_c != SINCRONIA);
         bus.vsync_n       <= (v_fase_sig_c != SINCRONIA);
         bus.video_activo  <= (h_fase_sig_c == VISIBLE) && (v_fase_sig_c == VISIBLE);
         bus.inicio_cuadro <= v_envuelve_c;
         bus.permiso       <= bus.solicitud & ventana_sig_c;
      end
   end

endmodule

// File: tb/tb_controlador_vga.sv
// Bench for controlador_vga: reduced-timing instance checked against a queued reference
// model every cycle, plus a default 640x480 instance checked on reset and one full line.
module tb_controlador_vga;
   import vga_pkg::*;

   localparam int unsigned HV = 20, HPF = 4, HS = 6, HPT = 5;
   localparam int unsigned VV = 12, VPF = 2, VS = 2, VPT = 3;
   localparam int unsigned G  = 1;
   localparam int unsigned HT = HV + HPF + HS + HPT;
   localparam int unsigned VT = VV + VPF + VS + VPT;
   localparam int unsigned CUADRO = HT * VT;

   typedef struct packed {
      logic [ANCHO-1:0] col;
      logic [ANCHO-1:0] fil;
      logic             hs;
      logic             vs;
      logic             va;
      logic             ini;
      logic             perm;
   } sal_t;

   logic reloj = 1'b0;
   logic reset;
   always #5 reloj = ~reloj;

   controlador_vga_if bus ();
   controlador_vga_if bus_def ();

   assign bus_def.pulso_pixel = bus.pulso_pixel;
   assign bus_def.solicitud   = 1'b0;

   controlador_vga #(
      .H_VISIBLE (HV), .H_PF (HPF), .H_SYNC (HS), .H_PT (HPT),
      .V_VISIBLE (VV), .V_PF (VPF), .V_SYNC (VS), .V_PT (VPT),
      .GUARDA    (G)
   ) dut (
      .reloj (reloj),
      .reset (reset),
      .bus   (bus)
   );

   controlador_vga dut_def (
      .reloj (reloj),
      .reset (reset),
      .bus   (bus_def)
   );

   sal_t        esperado_q[$];
   int          vectors = 0;
   int          miscompares = 0;
   int unsigned m_col;
   int unsigned m_fil;

   function automatic sal_t salida(input int unsigned c, input int unsigned f,
                                   input logic ini, input logic perm);
      sal_t r;
      r.col  = ANCHO'(c);
      r.fil  = ANCHO'(f);
      r.hs   = !(c >= HV + HPF && c < HV + HPF + HS);
      r.vs   = !(f >= VV + VPF && f < VV + VPF + VS);
      r.va   = (c < HV) && (f < VV);
      r.ini  = ini;
      r.perm = perm;
      return r;
   endfunction

   function automatic sal_t leer();
      return '{bus.columna, bus.fila, bus.hsync_n, bus.vsync_n,
               bus.video_activo, bus.inicio_cuadro, bus.permiso};
   endfunction

   task automatic modelo_reset();
      m_col = HT - 1;
      m_fil = VT - 1;
      esperado_q.delete();
   endtask

   // Drive one cycle, advance the model and queue what the DUT must show after the edge.
   task automatic paso(input logic p, input logic s);
      logic ini;
      logic perm;
      bus.pulso_pixel = p;
      bus.solicitud   = s;
      if (p) begin
         if (m_col == HT - 1) begin
            m_col = 0;
            m_fil = (m_fil == VT - 1) ? 0 : m_fil + 1;
         end else begin
            m_col = m_col + 1;
         end
      end
      ini  = p && m_col == 0 && m_fil == 0;
      perm = s && m_fil >= VV && m_fil < VT - G;
      esperado_q.push_back(salida(m_col, m_fil, ini, perm));
      @(posedge reloj);
      #1;
   endtask

   task automatic test_reset();
      sal_t e, o;
      bus.pulso_pixel = 1'b0;
      bus.solicitud   = 1'b0;
      @(posedge reloj); #1;
      reset = 1'b1;
      #1;
      modelo_reset();
      e = salida(HT - 1, VT - 1, 1'b0, 1'b0);
      o = leer();
      vectors++;
      if (o !== e) begin
         miscompares++;
         $display("FAIL reset_values: got %h want %h", o, e);
      end
      vectors++;
      if (bus_def.columna !== 10'd799 || bus_def.fila !== 10'd524 || bus_def.hsync_n !== 1'b1 ||
          bus_def.vsync_n !== 1'b1 || bus_def.video_activo !== 1'b0 || bus_def.inicio_cuadro !== 1'b0 ||
          bus_def.permiso !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_default: got col=%0d fil=%0d hs=%b vs=%b va=%b ini=%b perm=%b want 799/524/1/1/0/0/0",
                  bus_def.columna, bus_def.fila, bus_def.hsync_n, bus_def.vsync_n,
                  bus_def.video_activo, bus_def.inicio_cuadro, bus_def.permiso);
      end
      @(negedge reloj);
      reset = 1'b0;
      for (int i = 0; i < 2; i++) begin
         paso(1'b1, 1'b0);
         e = esperado_q.pop_front();
         o = leer();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL first_ticks[%0d]: got %h want %h", i, o, e);
         end
         vectors++;
         if (bus.inicio_cuadro !== (i == 0) || (i == 0 && (bus.columna !== 0 || bus.fila !== 0 || bus.video_activo !== 1'b1))) begin
            miscompares++;
            $display("FAIL first_tick_origin[%0d]: got col=%0d fil=%0d va=%b ini=%b", i,
                     bus.columna, bus.fila, bus.video_activo, bus.inicio_cuadro);
         end
      end
   endtask

   task automatic test_line();
      sal_t e, o;
      int   hs_bajo = 0;
      int   va_cae  = -1;
      for (int i = 0; i < int'(HT) - 1; i++) begin
         paso(1'b1, 1'b0);
         e = esperado_q.pop_front();
         o = leer();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL line_tick[%0d]: got %h want %h", i, o, e);
         end
         if (!bus.hsync_n) hs_bajo++;
         if (!bus.video_activo && va_cae < 0) va_cae = int'(bus.columna);
      end
      vectors++;
      if (hs_bajo != int'(HS) || va_cae != int'(HV) || bus.columna !== 0 || bus.fila !== 1) begin
         miscompares++;
         $display("FAIL line_shape: hsync_low=%0d video_off_col=%0d end=(%0d,%0d) want %0d %0d (0,1)",
                  hs_bajo, va_cae, bus.columna, bus.fila, HS, HV);
      end
   endtask

   task automatic test_frame();
      sal_t e, o;
      int   n = 0;
      int   ticks = 0;
      int   vs_bajo = 0;
      while (!bus.inicio_cuadro && n < int'(2 * CUADRO)) begin
         paso(1'b1, 1'b0);
         e = esperado_q.pop_front();
         o = leer();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL frame_seek[%0d]: got %h want %h", n, o, e);
         end
         n++;
      end
      do begin
         paso(1'b1, 1'b0);
         e = esperado_q.pop_front();
         o = leer();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL frame_tick[%0d]: got %h want %h", ticks, o, e);
         end
         if (!bus.vsync_n) vs_bajo++;
         ticks++;
      end while (!bus.inicio_cuadro && ticks < int'(2 * CUADRO));
      vectors++;
      if (ticks != int'(CUADRO) || vs_bajo != int'(VS * HT)) begin
         miscompares++;
         $display("FAIL frame_period: ticks=%0d vsync_low_ticks=%0d want %0d %0d",
                  ticks, vs_bajo, CUADRO, VS * HT);
      end
   endtask

   task automatic test_grant_hold();
      sal_t e, o;
      logic prev = 1'b0;
      int   sube_f = -1, sube_c = -1, baja_f = -1, baja_c = -1;
      int   n = 0;
      while (m_fil != 5 && n < int'(2 * CUADRO)) begin
         paso(1'b1, 1'b0);
         e = esperado_q.pop_front();
         o = leer();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL grant_seek[%0d]: got %h want %h", n, o, e);
         end
         n++;
      end
      n = 0;
      do begin
         paso(1'b1, 1'b1);
         e = esperado_q.pop_front();
         o = leer();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL grant_hold[%0d]: got %h want %h", n, o, e);
         end
         if (bus.permiso && !prev) begin sube_f = int'(bus.fila); sube_c = int'(bus.columna); end
         if (!bus.permiso && prev) begin baja_f = int'(bus.fila); baja_c = int'(bus.columna); end
         prev = bus.permiso;
         n++;
      end while (m_fil != 0 && n < int'(2 * CUADRO));
      vectors++;
      if (sube_f != int'(VV) || sube_c != 0 || baja_f != int'(VT - G) || baja_c != 0) begin
         miscompares++;
         $display("FAIL grant_window: rise=(%0d,%0d) fall=(%0d,%0d) want (0,%0d) (0,%0d)",
                  sube_c, sube_f, baja_c, baja_f, VV, VT - G);
      end
   endtask

   task automatic test_grant_pulse();
      sal_t e, o;
      logic p_seq [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      logic s_seq [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      int   n = 0;
      while (m_fil != VV + 2 && n < int'(4 * CUADRO)) begin
         paso(1'($urandom_range(0, 1)), 1'b0);
         e = esperado_q.pop_front();
         o = leer();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL pulse_seek[%0d]: got %h want %h", n, o, e);
         end
         n++;
      end
      // Raise, hold, drop and re-raise; only the last step carries a pixel tick.
      for (int i = 0; i < 4; i++) begin
         paso(p_seq[i], s_seq[i]);
         e = esperado_q.pop_front();
         o = leer();
         vectors++;
         if (o !== e || bus.permiso !== s_seq[i]) begin
            miscompares++;
            $display("FAIL grant_pulse[%0d]: got %h perm=%b want %h perm=%b", i, o, bus.permiso, e, s_seq[i]);
         end
      end
   endtask

   task automatic test_random();
      sal_t e, o;
      for (int i = 0; i < 1500; i++) begin
         paso(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0));
         e = esperado_q.pop_front();
         o = leer();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL random[%0d]: got %h want %h", i, o, e);
         end
      end
   endtask

   task automatic test_hold_reset();
      sal_t e, o, congelado;
      int   n = 0;
      time  t0;
      while (!(m_fil == VV + 1 && m_col == 10) && n < int'(2 * CUADRO)) begin
         paso(1'b1, 1'b1);
         e = esperado_q.pop_front();
         o = leer();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL hold_seek[%0d]: got %h want %h", n, o, e);
         end
         n++;
      end
      congelado = leer();
      for (int i = 0; i < 50; i++) begin
         paso(1'b0, 1'b1);
         e = esperado_q.pop_front();
         o = leer();
         vectors++;
         if (o !== e || o !== congelado || !bus.permiso) begin
            miscompares++;
            $display("FAIL hold_freeze[%0d]: got %h want %h", i, o, e);
         end
      end
      t0 = $time;
      reset = 1'b1;
      #1;
      modelo_reset();
      e = salida(HT - 1, VT - 1, 1'b0, 1'b0);
      o = leer();
      vectors++;
      if (o !== e || ($time - t0) >= 4) begin
         miscompares++;
         $display("FAIL async_reset: got %h want %h", o, e);
      end
      @(negedge reloj);
      reset = 1'b0;
   endtask

   task automatic test_default_line();
      sal_t e, o;
      int   hs_bajo = 0, hs_ini = -1, hs_fin = -1, va_cae = -1;
      for (int i = 0; i < 800; i++) begin
         paso(1'b1, 1'b0);
         e = esperado_q.pop_front();
         o = leer();
         vectors++;
         if (o !== e) begin
            miscompares++;
            $display("FAIL default_side[%0d]: got %h want %h", i, o, e);
         end
         if (!bus_def.hsync_n) begin
            hs_bajo++;
            if (hs_ini < 0) hs_ini = int'(bus_def.columna);
            hs_fin = int'(bus_def.columna);
         end
         if (!bus_def.video_activo && va_cae < 0) va_cae = int'(bus_def.columna);
      end
      vectors++;
      if (hs_bajo != 96 || hs_ini != 656 || hs_fin != 751 || va_cae != 640 ||
          bus_def.columna !== 10'd799 || bus_def.fila !== 10'd0) begin
         miscompares++;
         $display("FAIL default_line: hsync %0d cols %0d-%0d video_off=%0d end=(%0d,%0d) want 96 656-751 640 (799,0)",
                  hs_bajo, hs_ini, hs_fin, va_cae, bus_def.columna, bus_def.fila);
      end
   endtask

   initial begin
      reset = 1'b0;
      bus.pulso_pixel = 1'b0;
      bus.solicitud   = 1'b0;
      test_reset();
      test_line();
      test_frame();
      test_grant_hold();
      test_grant_pulse();
      test_random();
      test_hold_reset();
      test_default_line();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
